// File: rtl/rx_fsm.sv
// rx_fsm: UART receive controller.
// Oversamples rx at OVERSAMPLE x baud, rejects start-bit glitches, deserialises
// DATA_BITS LSB-first and checks the stop bit. Each completed frame, good or bad,
// produces a one-cycle rx_valid strobe with rx_data and the error flags.
// Optional feature macro: RX_PARITY_EN adds a parity bit after the data bits
// (even or odd according to PARITY_ODD). Without it parity_err is tied low.
module rx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 fast_baud_clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
`ifdef RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
`endif

  // Reject parameter sets the counters and shift register are not sized for.
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("rx_fsm: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [TW-1:0]        tick_reg, tick_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg, ferr_next;
  logic                 perr_reg, perr_next;
`ifdef RX_PARITY_EN
  logic                 par_bit_reg, par_bit_next;
`endif

  logic       sync1_reg, rx_s_reg, rx_s_prev_reg;
  logic [1:0] settle_reg;
  logic       start_edge;
  logic       tick_wrap;
  logic [TW-1:0] tick_adv;

  // Two-flop synchroniser plus previous-sample flop for falling-edge detection.
  // settle_reg blocks edge detection until the preset-high flops have been
  // replaced by real line samples, so a line held low through reset is not
  // mistaken for a start bit.
  always_ff @(posedge fast_baud_clk) begin
    if (reset) begin
      sync1_reg     <= 1'b1;
      rx_s_reg      <= 1'b1;
      rx_s_prev_reg <= 1'b1;
      settle_reg    <= 2'd0;
    end else begin
      sync1_reg     <= rx;
      rx_s_reg      <= sync1_reg;
      rx_s_prev_reg <= rx_s_reg;
      if (settle_reg != 2'd3) begin
        settle_reg <= settle_reg + 2'd1;
      end
    end
  end

  assign start_edge = (settle_reg == 2'd3) && rx_s_prev_reg && !rx_s_reg;
  assign tick_wrap  = (tick_reg == TICK_LAST);
  assign tick_adv   = tick_wrap ? '0 : tick_reg + 1'b1;

  // State, counters, shift register and output registers.
  always_ff @(posedge fast_baud_clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      perr_reg    <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
      perr_reg    <= perr_next;
`ifdef RX_PARITY_EN
      par_bit_reg <= par_bit_next;
`endif
    end
  end

  // Next-state and datapath decisions; everything holds unless a state acts.
  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    ferr_next    = ferr_reg;
    perr_next    = perr_reg;
`ifdef RX_PARITY_EN
    par_bit_next = par_bit_reg;
`endif
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        if (start_edge) begin
          state_next = START;
        end
      end
      START: begin
        // Mid-point of the start bit: a line back high was only a glitch.
        if (tick_reg == TICK_MID) begin
          tick_next = '0;
          if (rx_s_reg) begin
            state_next = IDLE;
          end else begin
            bit_next   = '0;
            state_next = DATA;
          end
        end else begin
          tick_next = tick_reg + 1'b1;
        end
      end
      DATA: begin
        tick_next = tick_adv;
        if (tick_wrap) begin
          // Shift in at the MSB side so the first (LSB) bit ends at bit 0.
          shift_next = {rx_s_reg, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == BIT_LAST) begin
            bit_next = '0;
`ifdef RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        tick_next = tick_adv;
        if (tick_wrap) begin
          par_bit_next = rx_s_reg;
          state_next   = STOP;
        end
      end
`endif
      STOP: begin
        tick_next = tick_adv;
        if (tick_wrap) begin
          // Outputs update on the stop sample; IDLE is already armed while
          // rx_valid is high so a back-to-back start edge is not missed.
          data_next  = shift_reg;
          ferr_next  = ~rx_s_reg;
`ifdef RX_PARITY_EN
          perr_next  = ((^shift_reg) ^ par_bit_reg) != ODD_BIT;
`else
          perr_next  = 1'b0;
`endif
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data   = data_reg;
  assign rx_valid  = valid_reg;
  assign rx_busy   = (state_reg != IDLE);
  assign frame_err = ferr_reg;
`ifdef RX_PARITY_EN
  assign parity_err = perr_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule
